pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core: pc, if, id, ex, mem and wb.
- Merges stall requests from id, ex and mem into the 6-bit stall vector consumed by every pipeline register, including mem/wb.
- Turns mem-stage exceptions into a one-cycle flush plus redirect PC, then masks further exceptions for a short recovery window.
- Keeps stall and flush statistics counters for software.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for every non-eret exception.
- RECOVER_CYCLES, 2, cycles after a flush during which excepttype is ignored (1..15).
- WDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (feature-gated).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stallreq_id  in  1  id stage requests stall (load-use hazard)
- stallreq_ex  in  1  ex stage requests stall (multi-cycle mult/div)
- stallreq_mem  in  1  mem stage requests stall (bus wait)
- excepttype  in  32  mem-stage exception code; 0 = none
- cp0_epc  in  32  current EPC, used for eret
- stall  out  6  bit0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb; 1 = Stop
- flush  out  1  clears all pipeline registers this cycle
- new_pc  out  32  redirect target, valid while flush=1
- busy  out  1  high while in FLUSH or RECOVER
- stall_cycles  out  32  count of cycles with stall != 0
- flush_count  out  16  count of flushes taken
- wdog_err  out  1  sticky watchdog flag (0 when feature is absent)

Behaviour:
- Reset (synchronous): state=IDLE, recover counter=0, stall_cycles=0, flush_count=0, wdog_err=0.
- All outputs are defined during reset: stall=0, flush=0, new_pc=0, busy=0.
- stall is combinational (Mealy), zero latency, and only for requests not overridden by a flush:
  - stallreq_mem → 6'b011111
  - else stallreq_ex → 6'b001111
  - else stallreq_id → 6'b000111
  - else 6'b000000
  - wb (bit5) never stalls.
- States: IDLE, FLUSH, RECOVER.
- IDLE with excepttype != 0, in cycle T (combinational):
  - flush=1 and stall=0, overriding any stallreq.
  - new_pc = cp0_epc if excepttype == 32'h0000000e (eret), else EXC_VECTOR.
  - The next state is FLUSH.
- Exception in the same cycle as stallreq_mem: the exception wins and the stall is dropped. The mem side must abort its bus cycle on flush.
- FLUSH lasts exactly one cycle:
  - flush=0, stall=0, busy=1; flush_count increments by 1, saturating at 16'hFFFF.
  - Recover counter is loaded with RECOVER_CYCLES-1; next state is RECOVER.
- RECOVER:
  - excepttype is ignored; the stall mapping above applies normally; busy=1.
  - Counter decrements; at 0 return to IDLE.
  - An exception arriving on the last RECOVER cycle is ignored. Mem must hold it, otherwise it is lost by design.
- new_pc holds its last value when flush=0.
- stall_cycles increments each cycle that the stall output is non-zero, and wraps modulo 2^32.
- Reset asserted mid-FLUSH or mid-RECOVER returns to IDLE on the next edge with counters cleared.

Optional Feature:
- Macro: PIPE_STALL_WDOG_EN.
- Enabled:
  - A 16-bit counter counts consecutive cycles with stall != 0 and clears on any cycle where stall == 0.
  - When it reaches WDOG_LIMIT in IDLE, a forced flush is taken in that cycle: flush=1, new_pc=EXC_VECTOR, then FLUSH → RECOVER as normal.
  - wdog_err sets and stays set until rst; the counter clears.
- Disabled: no counter, and wdog_err is tied to 0.

Test Plan:
- Reset with all requests=1 → stall=0, flush=0, counters=0. After rst falls with stallreq_mem=1 → stall=6'b011111 the same cycle; stall_cycles=1 after the edge.
- stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111. Drop ex → 6'b000111; drop all → 0.
- excepttype=32'h00000008 in IDLE → flush=1, new_pc=32'h00000020 for one cycle. busy=1 for 1+RECOVER_CYCLES=3 cycles; flush_count=1.
- excepttype=32'h0000000e with cp0_epc=32'h00001234 → new_pc=32'h00001234. A second exception during RECOVER → no flush.
- stallreq_mem=1 plus excepttype=32'h0000000c in the same cycle → stall=0, flush=1.
- With PIPE_STALL_WDOG_EN and WDOG_LIMIT=8, hold stallreq_ex=1 → flush=1 on the 9th stalled cycle with new_pc=EXC_VECTOR; wdog_err stays 1 until rst.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-to-sequencer bundle: stall requests and exception info in,
// stall vector, flush and redirect PC out.
interface pipe_stall_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;

    // Pipeline side
    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        input  stall, flush, new_pc, busy
    );

    // Sequencer side
    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        output stall, flush, new_pc, busy
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core with statistics counters.
// Optional stall watchdog enabled by defining PIPE_STALL_WDOG_EN.
module pipe_stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'h00000020,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   pif,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_count,
    output logic               wdog_err
);

    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

    localparam logic [3:0]  RCNT_INIT = 4'(RECOVER_CYCLES - 1);
    localparam logic [31:0] ERET_CODE = 32'h0000000e;

    state_t      state;
    logic [3:0]  rcnt;
    logic [31:0] pc_q;
    logic        take_flush;
    logic        wdog_trip;
    logic [5:0]  req_stall;
    logic [31:0] exc_pc;

    always_comb begin
        req_stall = 6'b000000;
        if (pif.stallreq_mem)
            req_stall = 6'b011111;
        else if (pif.stallreq_ex)
            req_stall = 6'b001111;
        else if (pif.stallreq_id)
            req_stall = 6'b000111;

        exc_pc     = (pif.excepttype == ERET_CODE) ? pif.cp0_epc : EXC_VECTOR;
        take_flush = !rst && (state == IDLE) && ((pif.excepttype != '0) || wdog_trip);

        // A flush (this cycle or its FLUSH follow-up) overrides every stall request
        pif.stall  = (rst || take_flush || state == FLUSH) ? '0 : req_stall;
        pif.flush  = take_flush;
        pif.new_pc = rst ? '0 : (take_flush ? exc_pc : pc_q);
        pif.busy   = !rst && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rcnt         <= '0;
            pc_q         <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pif.stall != '0)
                stall_cycles <= stall_cycles + 32'd1;
            if (take_flush)
                pc_q <= exc_pc;

            case (state)
                IDLE: begin
                    if (take_flush)
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (flush_count != '1)
                        flush_count <= flush_count + 16'd1;
                    rcnt  <= RCNT_INIT;
                    state <= RECOVER;
                end
                RECOVER: begin
                    if (rcnt == '0)
                        state <= IDLE;
                    else
                        rcnt <= rcnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_STALL_WDOG_EN
    logic [15:0] wcnt;

    assign wdog_trip = ({16'b0, wcnt} >= WDOG_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt     <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (take_flush && wdog_trip)
                wdog_err <= 1'b1;
            if (pif.stall == '0)
                wcnt <= '0;
            else if (wcnt != '1)
                wcnt <= wcnt + 16'd1;
        end
    end
`else
    logic unused_wdog_limit;

    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_trip         = 1'b0;
    assign wdog_err          = 1'b0;
`endif

endmodule
